// File: rtl/arith_pkg.sv
// Shared arithmetic-datapath definitions for the sequential unsigned divider.
package arith_pkg;

    localparam int unsigned DIV_W     = 4;
    localparam int unsigned DIV_CNT_W = $clog2(2 * DIV_W);

    // Quotient reported when the divisor is zero.
    localparam logic [2*DIV_W-1:0] DIV_DBZ_QUOTIENT = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {R, Q-msb} left and trial-subtract the divisor.
module div_step
    import arith_pkg::*;
#(
    parameter int unsigned W = DIV_W
) (
    input  logic [W:0]   r_i,
    input  logic         q_msb_i,
    input  logic [W-1:0] divisor_i,
    output logic [W:0]   r_o,
    output logic         q_bit_o
);

    logic [W+1:0] sh;

    // R stays below the divisor, so the W+2-bit shifted value never overflows.
    always_comb begin
        sh      = {r_i, q_msb_i};
        q_bit_o = (sh >= (W+2)'(divisor_i));
        r_o     = q_bit_o ? (W+1)'(sh - (W+2)'(divisor_i)) : (W+1)'(sh);
    end

endmodule

// File: rtl/seq_div_unsigned.sv
// Iterative unsigned restoring divider, one quotient bit per clock, valid/ready on both sides.
module seq_div_unsigned
    import arith_pkg::*;
#(
    parameter int unsigned W = DIV_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2*W-1:0]   dividend,
    input  logic [W-1:0]     divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   quotient,
    output logic [W-1:0]     remainder,
    output logic             div_by_zero
);

    localparam int unsigned QW    = 2 * W;
    localparam int unsigned CNT_W = (W == DIV_W) ? DIV_CNT_W : $clog2(2 * W);
    localparam logic [QW-1:0] DBZ_Q = (W == DIV_W) ? QW'(DIV_DBZ_QUOTIENT) : {QW{1'b1}};

    div_state_e       state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [W:0]       r_q, r_d;
    logic [QW-1:0]    q_q, q_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     div_q, div_d;
    logic [QW-1:0]    quot_q, quot_d;
    logic [W-1:0]     rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic [W:0]       step_r;
    logic             step_q;

    div_step #(
        .W (W)
    ) u_step (
        .r_i       (r_q),
        .q_msb_i   (q_q[QW-1]),
        .divisor_i (div_q),
        .r_o       (step_r),
        .q_bit_o   (step_q)
    );

    // Next-state and result-register logic.
    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        r_d         = r_q;
        q_d         = q_q;
        cnt_d       = cnt_q;
        div_d       = div_q;
        quot_d      = quot_q;
        rem_d       = rem_q;
        dbz_d       = dbz_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    div_d      = divisor;
                    in_ready_d = 1'b0;
                    if (divisor == '0) begin
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                        quot_d      = DBZ_Q;
                        rem_d       = '0;
                        dbz_d       = 1'b1;
                    end else begin
                        state_d = CALC;
                        r_d     = '0;
                        q_d     = dividend;
                        cnt_d   = CNT_W'(QW - 1);
                        dbz_d   = 1'b0;
                    end
                end
            end

            CALC: begin
                r_d   = step_r;
                q_d   = {q_q[QW-2:0], step_q};
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    quot_d      = {q_q[QW-2:0], step_q};
                    rem_d       = step_r[W-1:0];
                end
            end

            DONE: begin
                // Returning to IDLE here blocks any accept on the handshake edge.
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end

            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            r_q         <= '0;
            q_q         <= '0;
            cnt_q       <= '0;
            div_q       <= '0;
            quot_q      <= '0;
            rem_q       <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            r_q         <= r_d;
            q_q         <= q_d;
            cnt_q       <= cnt_d;
            div_q       <= div_d;
            quot_q      <= quot_d;
            rem_q       <= rem_d;
            dbz_q       <= dbz_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule
